// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared state encoding and constants for the sequential signed divider
package seq_div_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        DIVIDE = 3'd2,
        FIXUP  = 3'd3,
        DONE   = 3'd4
    } div_state_t;

    localparam logic [7:0] Q_MAX = 8'h7F;
    localparam logic [7:0] Q_MIN = 8'h80;
    localparam int         ITER  = 16;
    localparam int         CNT_W = 5;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_restore_step #(
    parameter int N = 8
) (
    input  logic [N:0] rem_in,
    input  logic       dvd_bit,
    input  logic [N:0] dvs_mag,
    output logic [N:0] rem_out,
    output logic       q_bit
);

    logic [N+1:0] trial;
    logic [N+1:0] diff;

    // rem_in < dvs_mag <= 2^(N-1), so the shifted trial always fits in N+1 bits
    always_comb begin
        trial   = {rem_in, dvd_bit};
        diff    = trial - {1'b0, dvs_mag};
        q_bit   = (trial >= {1'b0, dvs_mag});
        rem_out = q_bit ? diff[N:0] : trial[N:0];
    end

endmodule

// File: rtl/seq_booth_divider.sv
// rtl/seq_booth_divider.sv - iterative signed 2N/N divider with saturation and divide-by-zero flag
module seq_booth_divider
    import seq_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam logic [2*N-1:0] MAG_POS_MAX = (2*N)'(Q_MAX);
    localparam logic [2*N-1:0] MAG_NEG_MAX = (2*N)'(Q_MAX) + (2*N)'(1);

    div_state_t       state;
    logic [2*N-1:0]   dvd_r;
    logic [N-1:0]     dvs_r;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             zero_r;
    logic [N:0]       rem_r;
    logic [N:0]       dvs_mag_r;
    logic [2*N-1:0]   qm_r;
    logic [CNT_W-1:0] cnt_r;

    logic [N:0]       rem_next;
    logic             q_bit;
    logic [N:0]       dvs_ext;
    logic [2*N-1:0]   dvd_mag;
    logic [N:0]       dvs_mag;
    logic             q_neg;
    logic             q_ovf;
    logic [N-1:0]     q_val;
    logic [N-1:0]     r_val;

    assign in_ready = (state == IDLE);

    // qm_r starts as |dividend| and shifts out MSB-first while quotient bits shift in
    div_restore_step #(.N(N)) u_step (
        .rem_in  (rem_r),
        .dvd_bit (qm_r[2*N-1]),
        .dvs_mag (dvs_mag_r),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        dvs_ext = {dvs_r[N-1], dvs_r};
        dvd_mag = dvd_neg ? (~dvd_r + (2*N)'(1)) : dvd_r;
        dvs_mag = dvs_neg ? (~dvs_ext + (N+1)'(1)) : dvs_ext;
        q_neg   = dvd_neg ^ dvs_neg;
        q_ovf   = q_neg ? (qm_r > MAG_NEG_MAX) : (qm_r > MAG_POS_MAX);
        q_val   = q_neg ? (~qm_r[N-1:0] + N'(1)) : qm_r[N-1:0];
        r_val   = dvd_neg ? (~rem_r[N-1:0] + N'(1)) : rem_r[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd_r       <= '0;
            dvs_r       <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            zero_r      <= 1'b0;
            rem_r       <= '0;
            dvs_mag_r   <= '0;
            qm_r        <= '0;
            cnt_r       <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        dvd_neg <= dividend[2*N-1];
                        dvs_neg <= divisor[N-1];
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    qm_r      <= dvd_mag;
                    dvs_mag_r <= dvs_mag;
                    rem_r     <= '0;
                    cnt_r     <= '0;
                    zero_r    <= (dvs_r == '0);
                    state     <= (dvs_r == '0) ? FIXUP : DIVIDE;
                end
                DIVIDE: begin
                    rem_r <= rem_next;
                    qm_r  <= {qm_r[2*N-2:0], q_bit};
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(ITER - 1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (zero_r) begin
                        quotient    <= '0;
                        remainder   <= dvd_r[N-1:0];
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= q_ovf ? (q_neg ? Q_MIN : Q_MAX) : q_val;
                        remainder   <= r_val;
                        overflow    <= q_ovf;
                        div_by_zero <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_divider.sv
// tb/tb_seq_booth_divider.sv - scoreboard bench for seq_booth_divider
module tb_seq_booth_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    int op_id  = 0;

    typedef struct {
        int         id;
        logic [7:0] q;
        logic [7:0] r;
        logic       ov;
        logic       dz;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [15:0] t_a  [10] = '{16'd100, 16'hFF9C, 16'd100, 16'hFF9C, 16'd1000,
                               16'h8000, 16'h8000, 16'hFB00, 16'd5, 16'd9};
    logic [7:0]  t_b  [10] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'd3, 8'd1, 8'hFF, 8'd10, 8'd0, 8'd3};
    logic [7:0]  t_q  [10] = '{8'h0E, 8'hF2, 8'hF2, 8'h0E, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00, 8'h03};
    logic [7:0]  t_r  [10] = '{8'h02, 8'hFE, 8'h02, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00};
    logic        t_ov [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t_dz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          t_lat[10] = '{18, 18, 18, 18, 18, 18, 18, 18, 2, 18};

    seq_booth_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got q=%0h with nothing pending, required no output", quotient);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("op%0d quotient", mon_e.id), quotient, mon_e.q);
                check($sformatf("op%0d remainder", mon_e.id), remainder, mon_e.r);
                check($sformatf("op%0d overflow", mon_e.id), overflow, mon_e.ov);
                check($sformatf("op%0d div_by_zero", mon_e.id), div_by_zero, mon_e.dz);
            end
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [7:0] eq,
                         input logic [7:0] er, input logic eov, input logic edz,
                         input int lat, input int hold);
        int n;
        bit seen_ready;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("op%0d wait_in_ready", op_id), in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        exp_q.push_back('{op_id, eq, er, eov, edz});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'hA5C3;
        divisor  = 8'h3C;
        n = 0;
        seen_ready = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) seen_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("op%0d latency", op_id), n, lat);
        check($sformatf("op%0d in_ready_busy", op_id), seen_ready, 0);
        for (int k = 0; k < hold; k++) begin
            check($sformatf("op%0d hold%0d quotient", op_id, k), quotient, eq);
            check($sformatf("op%0d hold%0d remainder", op_id, k), remainder, er);
            check($sformatf("op%0d hold%0d out_valid", op_id, k), out_valid, 1);
            check($sformatf("op%0d hold%0d in_ready", op_id, k), in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("op%0d out_valid_drop", op_id), out_valid, 0);
        check($sformatf("op%0d in_ready_rise", op_id), in_ready, 1);
        op_id++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset overflow", overflow, 0);
        check("reset div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_op(t_a[i], t_b[i], t_q[i], t_r[i], t_ov[i], t_dz[i], t_lat[i], 0);
        end

        out_ready = 1'b0;
        do_op(16'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 18, 5);

        // abort an operation partway through the divide phase
        dividend = 16'd500;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_abort in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(16'd77, 8'hFB, 8'hF1, 8'h02, 1'b0, 1'b0, 18, 0);

        for (int i = 0; i < 6; i++) begin
            int a, b, qt, rt;
            logic [7:0] eq;
            logic eov;
            a = int'($urandom_range(0, 65535)) - 32768;
            b = int'($urandom_range(0, 255)) - 128;
            if (b == 0) b = 7;
            qt  = a / b;
            rt  = a % b;
            eov = (qt > 127) || (qt < -128);
            eq  = eov ? ((qt > 127) ? 8'h7F : 8'h80) : qt[7:0];
            do_op(a[15:0], b[7:0], eq, rt[7:0], eov, 1'b0, 18, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
